// File: rtl/button_events_pkg.sv
// -----------------------------------------------------------------------------
// button_events_pkg
//   Shared constants for the display-board button word coming from
//   shiftregctl: bit position of every button, the default word width, and
//   the event record type used by consumers of the event stream.
//   No ports (package).
// -----------------------------------------------------------------------------
package button_events_pkg;

   // Bit positions inside the raw button word
   localparam int unsigned TEMP_ALARM  = 0;
   localparam int unsigned DIALL_CLICK = 1;
   localparam int unsigned DIALR_CLICK = 2;
   localparam int unsigned NAV_CLICK   = 3;
   localparam int unsigned NAV_D       = 4;
   localparam int unsigned NAV_R       = 5;
   localparam int unsigned NAV_L       = 6;
   localparam int unsigned NAV_U       = 7;
   localparam int unsigned SPARE2      = 8;
   localparam int unsigned SPARE1      = 9;
   localparam int unsigned TOUCH_IRQ   = 10;
   localparam int unsigned SPARE0      = 11;
   localparam int unsigned BTN_X       = 12;
   localparam int unsigned BTN_Y       = 13;
   localparam int unsigned BTN_A       = 14;
   localparam int unsigned BTN_B       = 15;

   localparam int unsigned NUM_BUTTONS = 16;

   // One serialised button event ('release' is a reserved word, hence is_release)
   typedef struct packed {
      logic       is_release;
      logic [3:0] index;
   } button_evt_t;

endpackage

// File: rtl/button_events_if.sv
// -----------------------------------------------------------------------------
// button_events_if
//   Valid/ready event stream carrying one button edge per transfer.
//   evt_valid   holding register full (master -> slave)
//   evt_ready   consumer accepts when evt_valid & evt_ready (slave -> master)
//   evt_release 0 = press, 1 = release (master -> slave)
//   evt_index   button index (master -> slave)
// -----------------------------------------------------------------------------
interface button_events_if #(
   parameter int unsigned WIDTH = 16
);
   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic             evt_valid;
   logic             evt_ready;
   logic             evt_release;
   logic [IDX_W-1:0] evt_index;

   modport master (output evt_valid, output evt_release, output evt_index, input evt_ready);
   modport slave  (input evt_valid, input evt_release, input evt_index, output evt_ready);
endinterface

// File: rtl/button_events_debounce_cell.sv
// -----------------------------------------------------------------------------
// button_events_debounce_cell
//   One button bit: 2-flop synchroniser, polarity normalise, stability
//   counter advanced on the shared sample tick, registered level and pulses.
//   clk, rst_n        clock, async active-low reset (already release-synchronised)
//   tick_i            one-cycle sample tick from the parent prescaler
//   raw_i             raw button bit
//   pressed_o         debounced level, 1 = held
//   press_pulse_o     one cycle when pressed_o rises
//   release_pulse_o   one cycle when pressed_o falls
// -----------------------------------------------------------------------------
module button_events_debounce_cell
   import button_events_pkg::*;
#(
   parameter bit          ACTIVE_LOW   = 1'b1,
   parameter int unsigned STABLE_TICKS = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick_i,
   input  logic raw_i,
   output logic pressed_o,
   output logic press_pulse_o,
   output logic release_pulse_o
);
   // Raw level of a released button; synchroniser resets to it so no false press
   localparam logic IDLE_LEVEL = ACTIVE_LOW ? 1'b1 : 1'b0;
   localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic             sync1_q, sync2_q;
   logic             pressed_q, pressed_d;
   logic             press_pulse_q, press_pulse_d;
   logic             release_pulse_q, release_pulse_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sample_s;

   // XOR with the idle level maps the raw bit to 1 = pressed for either polarity
   assign sample_s = sync2_q ^ IDLE_LEVEL;

   // Stability counter: the STABLE_TICKS-th consecutive disagreeing tick flips the level
   always_comb begin
      pressed_d       = pressed_q;
      cnt_d           = cnt_q;
      press_pulse_d   = 1'b0;
      release_pulse_d = 1'b0;
      if (tick_i) begin
         if (sample_s != pressed_q) begin
            if (cnt_q == CNT_LAST) begin
               pressed_d       = ~pressed_q;
               cnt_d           = '0;
               press_pulse_d   = ~pressed_q;
               release_pulse_d = pressed_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            cnt_d = '0;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Synchroniser, debounced level, counter and pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q         <= IDLE_LEVEL;
         sync2_q         <= IDLE_LEVEL;
         pressed_q       <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         cnt_q           <= '0;
      end else begin
         sync1_q         <= raw_i;
         sync2_q         <= sync1_q;
         pressed_q       <= pressed_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         cnt_q           <= cnt_d;
      end
   end

   assign pressed_o       = pressed_q;
   assign press_pulse_o   = press_pulse_q;
   assign release_pulse_o = release_pulse_q;
endmodule

// File: rtl/button_events.sv
// -----------------------------------------------------------------------------
// button_events
//   Debounces the raw shiftregctl button word and serialises edges into a
//   valid/ready event stream.
//   clk, reset_n        clock, async active-low reset (release synchronised here)
//   buttons_in          raw button word
//   pressed             debounced levels, 1 = held
//   press_pulse         one-cycle strobe per rising debounced level
//   release_pulse       one-cycle strobe per falling debounced level
//   overrun             sticky: an event was lost or collapsed
//   overrun_clr         synchronous clear of overrun (a same-cycle set wins)
//   evt                 event stream (button_events_if master)
// -----------------------------------------------------------------------------
module button_events
   import button_events_pkg::*;
#(
   parameter int unsigned WIDTH        = NUM_BUTTONS,
   parameter bit          ACTIVE_LOW   = 1'b1,
   parameter int unsigned TICK_CYCLES  = 50000,
   parameter int unsigned STABLE_TICKS = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] buttons_in,
   output logic [WIDTH-1:0] pressed,
   output logic [WIDTH-1:0] press_pulse,
   output logic [WIDTH-1:0] release_pulse,
   output logic             overrun,
   input  logic             overrun_clr,
   button_events_if.master  evt
);
   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned PRE_W = $clog2(TICK_CYCLES);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

   logic [1:0]       rst_sync_q;
   logic             rst_n_s;
   logic [PRE_W-1:0] presc_q, presc_d;
   logic             tick_s;
   logic [WIDTH-1:0] press_pend_q, press_pend_d, rel_pend_q, rel_pend_d;
   logic [WIDTH-1:0] any_pend_s, clr_mask_s, press_base_s, rel_base_s;
   logic [WIDTH-1:0] press_coll_s, press_dup_s, press_new_s;
   logic [WIDTH-1:0] rel_coll_s, rel_dup_s, rel_new_s;
   logic [IDX_W-1:0] pick_idx_s;
   logic             pick_valid_s, load_s, ovr_set_s;
   logic             evt_valid_q, evt_valid_d, evt_release_q, evt_release_d;
   logic [IDX_W-1:0] evt_index_q, evt_index_d;
   logic             overrun_q, overrun_d;

   // Reset synchroniser: assertion is immediate, release waits two clock edges
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end
   assign rst_n_s = rst_sync_q[1];

   // Free-running sample prescaler
   assign tick_s  = (presc_q == PRE_LAST);
   assign presc_d = tick_s ? '0 : presc_q + 1'b1;

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      button_events_debounce_cell #(
         .ACTIVE_LOW   (ACTIVE_LOW),
         .STABLE_TICKS (STABLE_TICKS)
      ) u_cell (
         .clk             (clk),
         .rst_n           (rst_n_s),
         .tick_i          (tick_s),
         .raw_i           (buttons_in[g]),
         .pressed_o       (pressed[g]),
         .press_pulse_o   (press_pulse[g]),
         .release_pulse_o (release_pulse[g])
      );
   end

   // Priority pick: descending scan so the lowest pending index wins
   always_comb begin
      pick_idx_s = '0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         pick_idx_s = any_pend_s[i] ? IDX_W'(i) : pick_idx_s;
      end
   end
   assign any_pend_s   = press_pend_q | rel_pend_q;
   assign pick_valid_s = |any_pend_s;
   assign load_s       = ~evt_valid_q | evt.evt_ready;
   assign clr_mask_s   = (load_s && pick_valid_s) ? (WIDTH'(1) << pick_idx_s) : '0;

   // Holding register: refill whenever empty or being taken, otherwise hold stable
   always_comb begin
      evt_valid_d   = evt_valid_q;
      evt_release_d = evt_release_q;
      evt_index_d   = evt_index_q;
      if (load_s) begin
         if (pick_valid_s) begin
            evt_valid_d   = 1'b1;
            evt_index_d   = pick_idx_s;
            evt_release_d = rel_pend_q[pick_idx_s];
         end else begin
            evt_valid_d = 1'b0;
         end
      end else begin
         evt_valid_d = evt_valid_q;
      end
   end

   // Enqueue is judged after the serialiser's clear, so a same-cycle set survives
   assign press_base_s = press_pend_q & ~clr_mask_s;
   assign rel_base_s   = rel_pend_q & ~clr_mask_s;
   assign press_coll_s = press_pulse & rel_base_s;
   assign press_dup_s  = press_pulse & press_base_s;
   assign press_new_s  = press_pulse & ~rel_base_s & ~press_base_s;
   assign rel_coll_s   = release_pulse & press_base_s;
   assign rel_dup_s    = release_pulse & rel_base_s;
   assign rel_new_s    = release_pulse & ~press_base_s & ~rel_base_s;
   // An opposite-kind edge cancels the pending one instead of queueing a pair
   assign press_pend_d = (press_base_s & ~rel_coll_s) | press_new_s;
   assign rel_pend_d   = (rel_base_s & ~press_coll_s) | rel_new_s;
   assign ovr_set_s    = |(press_coll_s | press_dup_s | rel_coll_s | rel_dup_s);
   assign overrun_d    = ovr_set_s | (overrun_q & ~overrun_clr);

   // Prescaler, pending masks, holding register and overrun flag
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         presc_q       <= '0;
         press_pend_q  <= '0;
         rel_pend_q    <= '0;
         evt_valid_q   <= 1'b0;
         evt_release_q <= 1'b0;
         evt_index_q   <= '0;
         overrun_q     <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         press_pend_q  <= press_pend_d;
         rel_pend_q    <= rel_pend_d;
         evt_valid_q   <= evt_valid_d;
         evt_release_q <= evt_release_d;
         evt_index_q   <= evt_index_d;
         overrun_q     <= overrun_d;
      end
   end

   assign evt.evt_valid   = evt_valid_q;
   assign evt.evt_release = evt_release_q;
   assign evt.evt_index   = evt_index_q;
   assign overrun         = overrun_q;
endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with TICK_CYCLES=4, STABLE_TICKS=3, ACTIVE_LOW=1.
// Expected events are queued when the stimulus is driven and popped by a
// negedge monitor on every completed handshake.
module tb_button_events;
   import button_events_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] buttons_in;
   logic [15:0] pressed, press_pulse, release_pulse;
   logic        overrun, overrun_clr;

   int n_vec = 0;
   int n_err = 0;
   int cyc_cnt = 0;
   int hs_cyc4 = -1;
   int hs_cyc12 = -1;
   button_evt_t sb[$];

   button_events_if #(.WIDTH(16)) evt_if ();

   button_events #(
      .WIDTH(16), .ACTIVE_LOW(1'b1), .TICK_CYCLES(4), .STABLE_TICKS(3)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .buttons_in    (buttons_in),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .overrun       (overrun),
      .overrun_clr   (overrun_clr),
      .evt           (evt_if.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor and backpressure stability check
   logic        prev_stall = 1'b0;
   logic [5:0]  prev_word = 6'd0;
   always @(negedge clk) begin
      button_evt_t e;
      cyc_cnt++;
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            chk("stall_hold", 64'({evt_if.evt_valid, evt_if.evt_release, evt_if.evt_index}), 64'(prev_word));
         if (evt_if.evt_valid && evt_if.evt_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_evt", 64'({evt_if.evt_release, evt_if.evt_index}), 64'h3F);
            end else begin
               e = sb.pop_front();
               chk("evt", 64'({evt_if.evt_release, evt_if.evt_index}), 64'(e));
               if (evt_if.evt_index == 4'd4) hs_cyc4 = cyc_cnt;
               if (evt_if.evt_index == 4'd12) hs_cyc12 = cyc_cnt;
            end
         end
         prev_stall = evt_if.evt_valid & ~evt_if.evt_ready;
         prev_word  = {evt_if.evt_valid, evt_if.evt_release, evt_if.evt_index};
      end
   end

   initial begin
      int first;
      int np, nr;
      reset_n = 1'b0;
      buttons_in = 16'hFFFF;
      overrun_clr = 1'b0;
      evt_if.evt_ready = 1'b1;

      // 1. Reset: everything idle during and after reset
      for (int i = 0; i < 50; i++) begin
         cyc(1);
         chk("reset_outs", 64'({pressed, press_pulse, release_pulse, evt_if.evt_valid, overrun}), 64'd0);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         chk("idle_outs", 64'({pressed, press_pulse, release_pulse, evt_if.evt_valid, overrun}), 64'd0);
      end

      // 2. Clean press of bit 1
      sb.push_back('{is_release: 1'b0, index: 4'd1});
      buttons_in[1] = 1'b0;
      first = 0; np = 0;
      for (int c = 1; c <= 30; c++) begin
         cyc(1);
         if (press_pulse[1]) np++;
         if (pressed[1] && first == 0) first = c;
      end
      chk("press1_lat_ok", 64'(first >= 1 && first <= 18), 64'd1);
      chk("press1_pulses", 64'(np), 64'd1);
      chk("press1_level", 64'(pressed), 64'h0002);
      chk("sb_drain2", 64'(sb.size()), 64'd0);

      // 3. Bounce on bit 2, then hold pressed
      sb.push_back('{is_release: 1'b0, index: 4'd2});
      np = 0; nr = 0;
      for (int k = 0; k < 10; k++) begin
         buttons_in[2] = (k % 2 == 0) ? 1'b0 : 1'b1;
         for (int j = 0; j < 3; j++) begin
            cyc(1);
            if (press_pulse[2]) np++;
            if (release_pulse[2]) nr++;
         end
      end
      buttons_in[2] = 1'b0;
      for (int c = 0; c < 30; c++) begin
         cyc(1);
         if (press_pulse[2]) np++;
         if (release_pulse[2]) nr++;
      end
      chk("bounce_press_pulses", 64'(np), 64'd1);
      chk("bounce_release_pulses", 64'(nr), 64'd0);
      chk("bounce_level", 64'(pressed), 64'h0006);
      chk("sb_drain3", 64'(sb.size()), 64'd0);

      // 4. Simultaneous presses of bits 12 and 4
      sb.push_back('{is_release: 1'b0, index: 4'd4});
      sb.push_back('{is_release: 1'b0, index: 4'd12});
      buttons_in[4] = 1'b0;
      buttons_in[12] = 1'b0;
      cyc(30);
      chk("simul_order_gap", 64'(hs_cyc12 - hs_cyc4), 64'd1);
      chk("simul_seen4", 64'(hs_cyc4 > 0), 64'd1);
      chk("simul_level", 64'(pressed), 64'h1016);
      chk("sb_drain4", 64'(sb.size()), 64'd0);
      chk("no_overrun_yet", 64'(overrun), 64'd0);

      // 5. Backpressure: release bit 1 fills the holding reg, bit 3 press+release collapses
      evt_if.evt_ready = 1'b0;
      sb.push_back('{is_release: 1'b1, index: 4'd1});
      buttons_in[1] = 1'b1;
      cyc(25);
      chk("bp_hold", 64'({evt_if.evt_valid, evt_if.evt_release, evt_if.evt_index}), 64'h31);
      buttons_in[3] = 1'b0;
      cyc(25);
      chk("bp_bit3_pressed", 64'(pressed[3]), 64'd1);
      buttons_in[3] = 1'b1;
      cyc(25);
      chk("bp_overrun_set", 64'(overrun), 64'd1);
      chk("bp_bit3_released", 64'(pressed), 64'h1014);
      chk("bp_hold2", 64'({evt_if.evt_valid, evt_if.evt_release, evt_if.evt_index}), 64'h31);
      overrun_clr = 1'b1;
      cyc(1);
      overrun_clr = 1'b0;
      chk("bp_overrun_clr", 64'(overrun), 64'd0);
      evt_if.evt_ready = 1'b1;
      cyc(10);
      chk("bp_drain", 64'(sb.size()), 64'd0);
      chk("bp_valid_low", 64'(evt_if.evt_valid), 64'd0);

      // 6. Async reset while an event is held and another is pending
      evt_if.evt_ready = 1'b0;
      buttons_in[5] = 1'b0;
      buttons_in[6] = 1'b0;
      cyc(25);
      chk("rst6_held", 64'({evt_if.evt_valid, evt_if.evt_release, evt_if.evt_index}), 64'h25);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst6_async_outs", 64'({pressed, press_pulse, release_pulse, evt_if.evt_valid, overrun}), 64'd0);
      chk("rst6_async_evt", 64'({evt_if.evt_release, evt_if.evt_index}), 64'd0);
      buttons_in = 16'hFFFF;
      evt_if.evt_ready = 1'b1;
      cyc(5);
      reset_n = 1'b1;
      cyc(40);
      chk("rst6_quiet", 64'({pressed, evt_if.evt_valid, overrun}), 64'd0);
      chk("sb_final", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
